// File: rtl/wave_pwm_dac.sv
// -----------------------------------------------------------------------------
// wave_pwm_dac
//   Turns each WIDTH-bit sample from the triangle-wave bus into a PWM duty
//   cycle that drives an RC-filtered analogue output. The wave input is
//   sampled once per PWM frame, at the frame end. The duty change per frame
//   is limited to MAX_STEP so the filtered output slews smoothly.
//
// Parameters
//   WIDTH     sample width; one frame is 2**WIDTH PWM counts
//   PRESCALE  clk cycles per PWM count (>= 1)
//   MAX_STEP  largest |duty change| allowed per frame (1 .. 2**WIDTH-1)
//
// Ports
//   clk          clock
//   rst_n        asynchronous, active-low reset
//   en           run enable; low parks the counters and forces pwm_out low
//   wave_in      unsigned sample, used only on the frame-end edge
//   pwm_out      registered PWM output
//   frame_start  one-clk pulse during the clk in which the counter reads 0
//   duty_q       duty currently applied
//   slew_active  the last duty update was clipped by MAX_STEP
// -----------------------------------------------------------------------------
module wave_pwm_dac #(
    parameter int WIDTH    = 5,
    parameter int PRESCALE = 1,
    parameter int MAX_STEP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] wave_in,
    output logic             pwm_out,
    output logic             frame_start,
    output logic [WIDTH-1:0] duty_q,
    output logic             slew_active
);

    // A 1-bit prescaler is kept for PRESCALE==1. It stays at 0, so tick is
    // high on every clk.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PW-1:0]       PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0]    CNT_LAST   = '1;
    localparam logic [WIDTH-1:0]    STEP_U     = WIDTH'(MAX_STEP);
    localparam logic signed [WIDTH:0] STEP_P   = (WIDTH+1)'(MAX_STEP);
    localparam logic signed [WIDTH:0] STEP_N   = -STEP_P;

    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_d;
    logic             slew_q, slew_d;
    logic             pwm_q, pwm_d;
    logic             fs_q, fs_d;

    logic             tick;
    logic             frame_end;
    logic signed [WIDTH:0] diff;

    assign tick      = (presc_q == PRESC_LAST);
    // en is part of the frame end, so a frame end that coincides with en low
    // produces no duty update and no pulse.
    assign frame_end = en & tick & (cnt_q == CNT_LAST);

    // Both operands are zero-extended by one bit, so the difference never
    // wraps. Its range is +/-(2**WIDTH-1).
    assign diff = $signed({1'b0, wave_in}) - $signed({1'b0, duty_q});

    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        duty_d  = duty_q;
        slew_d  = slew_q;
        pwm_d   = 1'b0;
        fs_d    = 1'b0;

        if (!en) begin
            // Abort any partial frame. duty_q and slew_active are held.
            presc_d = '0;
            cnt_d   = '0;
        end else begin
            // pwm_out follows the count with one clk of latency, so it uses
            // the pre-edge count and duty.
            pwm_d = (cnt_q < duty_q);

            if (tick) begin
                presc_d = '0;
                cnt_d   = cnt_q + 1'b1;   // natural wrap 2**WIDTH-1 -> 0
            end else begin
                presc_d = presc_q + 1'b1;
            end

            if (frame_end) begin
                fs_d = 1'b1;
                if (diff > STEP_P) begin
                    // No overflow: duty_q + MAX_STEP < wave_in.
                    duty_d = duty_q + STEP_U;
                    slew_d = 1'b1;
                end else if (diff < STEP_N) begin
                    // No underflow: duty_q - MAX_STEP > wave_in.
                    duty_d = duty_q - STEP_U;
                    slew_d = 1'b1;
                end else begin
                    duty_d = wave_in;
                    slew_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
            duty_q  <= '0;
            slew_q  <= 1'b0;
            pwm_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            slew_q  <= slew_d;
            pwm_q   <= pwm_d;
            fs_q    <= fs_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign frame_start = fs_q;
    assign slew_active = slew_q;

endmodule

// File: tb/tb_wave_pwm_dac.sv
// -----------------------------------------------------------------------------
// tb_wave_pwm_dac
//   Three instances share one stimulus stream:
//     0: PRESCALE=1, MAX_STEP=4
//     1: PRESCALE=1, MAX_STEP=31
//     2: PRESCALE=3, MAX_STEP=4
//   The reference model tracks the number of enabled clks since the current
//   frame started. It derives the count and the frame end arithmetically
//   from that number and applies the slew rule with integers. Directed
//   sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_wave_pwm_dac;

    localparam int N = 3;
    localparam int FRAME = 32;
    localparam int P [N] = '{1, 1, 3};
    localparam int M [N] = '{4, 31, 4};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [4:0] wave;

    logic       pwm_o  [N];
    logic       fs_o   [N];
    logic [4:0] duty_o [N];
    logic       slew_o [N];

    wave_pwm_dac #(.WIDTH(5), .PRESCALE(1), .MAX_STEP(4)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .wave_in(wave),
        .pwm_out(pwm_o[0]), .frame_start(fs_o[0]),
        .duty_q(duty_o[0]), .slew_active(slew_o[0]));
    wave_pwm_dac #(.WIDTH(5), .PRESCALE(1), .MAX_STEP(31)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .wave_in(wave),
        .pwm_out(pwm_o[1]), .frame_start(fs_o[1]),
        .duty_q(duty_o[1]), .slew_active(slew_o[1]));
    wave_pwm_dac #(.WIDTH(5), .PRESCALE(3), .MAX_STEP(4)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .wave_in(wave),
        .pwm_out(pwm_o[2]), .frame_start(fs_o[2]),
        .duty_q(duty_o[2]), .slew_active(slew_o[2]));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state: enabled clks into the current frame, duty, outputs
    int m_run  [N];
    int m_duty [N];
    int m_pwm  [N];
    int m_fs   [N];
    int m_slew [N];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0; m_duty[i] = 0; m_pwm[i] = 0; m_fs[i] = 0; m_slew[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                m_run[i] = 0; m_duty[i] = 0; m_pwm[i] = 0; m_fs[i] = 0; m_slew[i] = 0;
            end else if (!en) begin
                m_run[i] = 0; m_pwm[i] = 0; m_fs[i] = 0;
            end else begin
                int flen, pos, d;
                flen = FRAME * P[i];
                pos  = m_run[i] / P[i];
                m_pwm[i] = (pos < m_duty[i]) ? 1 : 0;
                if (m_run[i] == flen - 1) begin
                    d = int'(wave) - m_duty[i];
                    if (d > M[i])       begin m_duty[i] += M[i]; m_slew[i] = 1; end
                    else if (d < -M[i]) begin m_duty[i] -= M[i]; m_slew[i] = 1; end
                    else                begin m_duty[i] = int'(wave); m_slew[i] = 0; end
                    m_fs[i] = 1;
                end else begin
                    m_fs[i] = 0;
                end
                m_run[i] = (m_run[i] + 1) % flen;
            end
        end
    endtask

    task automatic compare();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("pwm%0d", i),  int'(pwm_o[i]),  m_pwm[i]);
            chk($sformatf("fs%0d", i),   int'(fs_o[i]),   m_fs[i]);
            chk($sformatf("duty%0d", i), int'(duty_o[i]), m_duty[i]);
            chk($sformatf("slew%0d", i), int'(slew_o[i]), m_slew[i]);
        end
    endtask

    // One clk: the model follows the active edge and the outputs are checked
    // on the falling edge. Inputs change only after this returns.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Count the pwm highs of instance i over n clks.
    task automatic count_high(input int i, input int n, output int hi, output int fsn);
        hi = 0; fsn = 0;
        for (int k = 0; k < n; k++) begin
            step();
            hi  += int'(pwm_o[i]);
            fsn += int'(fs_o[i]);
        end
    endtask

    // Count clks up to the next frame_start of instance i (bounded).
    task automatic wait_fs(input int i, input int lim, output int n);
        n = 0;
        while (n < lim) begin
            step();
            n++;
            if (fs_o[i]) break;
        end
    endtask

    int hi, fsn, n;
    int e3 [8] = '{4, 8, 12, 16, 20, 24, 28, 31};
    int e4 [8] = '{27, 23, 19, 15, 11, 7, 3, 0};

    initial begin
        rst_n = 1'b0; en = 1'b0; wave = 5'd0;
        model_reset();
        steps(3);
        for (int i = 0; i < N; i++) begin
            chk("rst_pwm",  int'(pwm_o[i]),  0);
            chk("rst_fs",   int'(fs_o[i]),   0);
            chk("rst_duty", int'(duty_o[i]), 0);
            chk("rst_slew", int'(slew_o[i]), 0);
        end
        rst_n = 1'b1;

        // constant 8 with an unlimited step: duty 8 after the first frame
        en = 1'b1; wave = 5'd8;
        steps(32);
        chk("t1_duty", int'(duty_o[1]), 8);
        chk("t1_fs",   int'(fs_o[1]), 1);
        count_high(1, 32, hi, fsn);
        chk("t1_high", hi, 8);
        chk("t1_fscnt", fsn, 1);

        // wave 0 -> never high, wave 31 -> low one count per frame
        wave = 5'd0;
        steps(32);
        chk("t2_duty0", int'(duty_o[1]), 0);
        count_high(1, 32, hi, fsn);
        chk("t2_high0", hi, 0);
        wave = 5'd31;
        steps(32);
        chk("t2_duty31", int'(duty_o[1]), 31);
        count_high(1, 32, hi, fsn);
        chk("t2_high31", hi, 31);

        // async reset between edges, then slew up from 0 to 31
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_duty", int'(duty_o[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int f = 0; f < 8; f++) begin
            steps(32);
            chk("t3_fs",   int'(fs_o[0]), 1);
            chk("t3_duty", int'(duty_o[0]), e3[f]);
            chk("t3_slew", int'(slew_o[0]), (f < 7) ? 1 : 0);
        end

        // slew down from 31 to 0, no underflow
        wave = 5'd0;
        for (int f = 0; f < 8; f++) begin
            steps(32);
            chk("t4_duty", int'(duty_o[0]), e4[f]);
            chk("t4_slew", int'(slew_o[0]), (f < 7) ? 1 : 0);
        end

        // bring instance 0 to duty 20, then drop en at count 12
        wave = 5'd20;
        steps(160);
        chk("t5_duty20", int'(duty_o[0]), 20);
        steps(12);
        chk("t5_pre_pwm", int'(pwm_o[0]), 1);
        en = 1'b0;
        step();
        chk("t5_pwm_off", int'(pwm_o[0]), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t5_fs_off", int'(fs_o[0]), 0);
            chk("t5_hold",   int'(duty_o[0]), 20);
        end
        en = 1'b1;
        wait_fs(0, 40, n);
        chk("t5_resume", n, 32);
        chk("t5_duty_after", int'(duty_o[0]), 20);

        // async reset mid-frame with duty 20 and pwm high
        steps(10);
        chk("t6_pre_pwm", int'(pwm_o[0]), 1);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_pwm",  int'(pwm_o[0]), 0);
        chk("t6_duty", int'(duty_o[0]), 0);
        chk("t6_fs",   int'(fs_o[0]), 0);
        chk("t6_slew", int'(slew_o[0]), 0);
        step();
        rst_n = 1'b1;

        // PRESCALE=3: frame every 96 clks
        wait_fs(2, 200, n);
        chk("t6_first96", n, 96);
        chk("t6_c_duty", int'(duty_o[2]), 4);
        wait_fs(2, 200, n);
        chk("t6_period96", n, 96);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
